fib_alu_sequencer: RTL and testbench

//   Control stage upstream of the 8-bit ALU (alu8). It generates Fibonacci terms F0..F(n-1) by

---
 rtl/fib_alu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fib_alu_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fib_alu_sequencer.sv
// ---------------------------------------------------------------------------
// fib_alu_sequencer
//   Control stage in front of an external 8-bit ALU. Produces Fibonacci terms
//   F0..F(n-1) by driving the ALU operands/opcode and capturing its result and
//   carry each cycle. Terms leave on a valid/ready stream. A run stops early
//   when the ALU carry reports an overflow of the datapath width.
//
//   Optional feature macro: FIB_PARITY_EN
//     defined   -> extra PARITY state after every ADD; the ALU computes b & 1
//                  and the LSB is presented on term_odd with each term.
//     undefined -> no PARITY state, term_odd tied low, AND never issued.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, n_terms    run request (sampled only in IDLE) and term count
//   busy, done        not-IDLE indicator, one-cycle end-of-run pulse
//   overflow          sticky: last run ended on ALU carry
//   term_valid/ready  term stream handshake
//   term_data/index   Fibonacci term and its index k
//   term_odd          term LSB as computed by the ALU (parity build only)
//   alu_left/right    ALU operands A/B
//   alu_status_in     ALU carry-in (always 0)
//   alu_opcode        ALU operation select
//   alu_status_out    ALU carry-out
//   alu_result        ALU result (combinational, same cycle)
// ---------------------------------------------------------------------------
module fib_alu_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter logic [1:0]  OP_ADD_VAL = 2'd0,
    parameter logic [1:0]  OP_AND_VAL = 2'd2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       n_terms,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             term_valid,
    input  logic             term_ready,
    output logic [WIDTH-1:0] term_data,
    output logic [7:0]       term_index,
    output logic             term_odd,
    output logic [WIDTH-1:0] alu_left,
    output logic [WIDTH-1:0] alu_right,
    output logic             alu_status_in,
    output logic [1:0]       alu_opcode,
    input  logic             alu_status_out,
    input  logic [WIDTH-1:0] alu_result
);

`ifdef FIB_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_EMIT, S_ADD, S_PARITY, S_DONE} state_e;
`else
    typedef enum logic [2:0] {S_IDLE, S_EMIT, S_ADD, S_DONE} state_e;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;     // F(k-1)
    logic [WIDTH-1:0]  b_q, b_d;     // F(k)
    logic [7:0]        idx_q, idx_d; // k
    logic [7:0]        n_q, n_d;     // captured term count
    logic              ovf_q, ovf_d;
`ifdef FIB_PARITY_EN
    logic              odd_q, odd_d;
`else
    // AND opcode only reaches the ALU when the parity stage is built in.
    logic [1:0]        unused_and_op;
    assign unused_and_op = OP_AND_VAL;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
`ifdef FIB_PARITY_EN
            odd_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
`ifdef FIB_PARITY_EN
            odd_q   <= odd_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        n_d        = n_q;
        ovf_d      = ovf_q;
`ifdef FIB_PARITY_EN
        odd_d      = odd_q;
`endif
        alu_left   = a_q;
        alu_right  = b_q;
        alu_opcode = OP_ADD_VAL;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d   = n_terms;
                    ovf_d = 1'b0;
                    if (n_terms == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // Seed a=F(-1)=1, b=F0=0 so the first ADD yields F1.
                        a_d     = WIDTH'(1);
                        b_d     = '0;
                        idx_d   = '0;
`ifdef FIB_PARITY_EN
                        odd_d   = 1'b0;
`endif
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (term_ready) begin
                    if (idx_q == n_q - 8'd1) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = S_ADD;
                    end
                end
            end
            S_ADD: begin
                if (alu_status_out) begin
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_d     = b_q;
                    b_d     = alu_result;
`ifdef FIB_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_EMIT;
`endif
                end
            end
`ifdef FIB_PARITY_EN
            S_PARITY: begin
                alu_left   = b_q;
                alu_right  = WIDTH'(1);
                alu_opcode = OP_AND_VAL;
                odd_d      = alu_result[0];
                state_d    = S_EMIT;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign term_valid    = (state_q == S_EMIT);
    assign term_data     = b_q;
    assign term_index    = idx_q;
    assign overflow      = ovf_q;
    assign alu_status_in = 1'b0;
`ifdef FIB_PARITY_EN
    assign term_odd      = odd_q;
`else
    assign term_odd      = 1'b0;
`endif

endmodule

// File: tb/tb_fib_alu_sequencer.sv
module tb_fib_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] n_terms;
    logic       busy, done, overflow, term_valid, term_ready, term_odd;
    logic [7:0] term_data, term_index;
    logic [7:0] alu_left, alu_right, alu_result;
    logic       alu_status_in, alu_status_out;
    logic [1:0] alu_opcode;
    logic [8:0] alu_t;

    int n_asserts = 0;
    int n_fail    = 0;

`ifdef FIB_PARITY_EN
    localparam int ACC_LAT = 3;
`else
    localparam int ACC_LAT = 2;
`endif

    always #5 clk = ~clk;

    fib_alu_sequencer #(.WIDTH(8), .OP_ADD_VAL(2'd0), .OP_AND_VAL(2'd2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
        .busy(busy), .done(done), .overflow(overflow),
        .term_valid(term_valid), .term_ready(term_ready),
        .term_data(term_data), .term_index(term_index), .term_odd(term_odd),
        .alu_left(alu_left), .alu_right(alu_right),
        .alu_status_in(alu_status_in), .alu_opcode(alu_opcode),
        .alu_status_out(alu_status_out), .alu_result(alu_result)
    );

    // Behavioural alu8: ADD/SUB/AND/OR with carry out in bit 8.
    always_comb begin
        case (alu_opcode)
            2'd0:    alu_t = {1'b0, alu_left} + {1'b0, alu_right} + {8'd0, alu_status_in};
            2'd1:    alu_t = {1'b0, alu_left} - {1'b0, alu_right} - {8'd0, alu_status_in};
            2'd2:    alu_t = {1'b0, alu_left & alu_right};
            default: alu_t = {1'b0, alu_left | alu_right};
        endcase
    end
    assign alu_result     = alu_t[7:0];
    assign alu_status_out = alu_t[8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
        check({tag, "_done"},  {31'd0, done},       32'd0);
        check({tag, "_ovf"},   {31'd0, overflow},   32'd0);
        check({tag, "_valid"}, {31'd0, term_valid}, 32'd0);
        check({tag, "_odd"},   {31'd0, term_odd},   32'd0);
        check({tag, "_data"},  {24'd0, term_data},  32'd0);
        check({tag, "_index"}, {24'd0, term_index}, 32'd0);
    endtask

    // One run: called at a negedge; returns at the negedge after done.
    task automatic run_seq(input int n, input int ready_pct, input int hold_idx);
        int  exp_q[$];
        int  fa, fb, ft;
        bit  exp_ovf, fin, prev_valid;
        int  got, last_acc, held, exp_done;

        // Reference: plain Fibonacci, emitted while it fits in 8 bits.
        fa = 1; fb = 0;
        for (int k = 0; k < n; k++) begin
            if (fb > 255) break;
            exp_q.push_back(fb);
            ft = fa + fb; fa = fb; fb = ft;
        end
        exp_ovf = (exp_q.size() < n);

        start   = 1'b1;
        n_terms = n[7:0];
        @(negedge clk);
        start   = 1'b0;
        n_terms = 8'($urandom);

        got = 0; last_acc = -1; held = 0; fin = 0; prev_valid = 0;
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (cyc == 0) begin
                check("busy_after_start", {31'd0, busy}, 32'd1);
                check("ovf_cleared",      {31'd0, overflow}, 32'd0);
            end
            check("alu_cin", {31'd0, alu_status_in}, 32'd0);
`ifndef FIB_PARITY_EN
            check("alu_op_add", {30'd0, alu_opcode}, 32'd0);
`endif
            term_ready = ($urandom_range(0, 99) < ready_pct);
            if (term_valid) begin
                if (got >= exp_q.size()) begin
                    check("extra_term_index", {24'd0, term_index}, 32'd9999);
                end else begin
                    check("term_index", {24'd0, term_index}, got);
                    check("term_data",  {24'd0, term_data},  exp_q[got]);
`ifdef FIB_PARITY_EN
                    check("term_odd", {31'd0, term_odd}, exp_q[got] % 2);
`else
                    check("term_odd", {31'd0, term_odd}, 32'd0);
`endif
                end
                if (!prev_valid)
                    check("valid_latency", cyc, (got == 0) ? 0 : last_acc + ACC_LAT);
                if (hold_idx >= 0 && int'(term_index) == hold_idx && held < 3) begin
                    term_ready = 1'b0;
                    held++;
                end
                if (term_ready) begin
                    got++;
                    last_acc = cyc;
                end
            end
            if (done) begin
                check("term_count", got, exp_q.size());
                check("overflow",   {31'd0, overflow}, {31'd0, exp_ovf});
                exp_done = (n == 0) ? 0 : (exp_ovf ? last_acc + 2 : last_acc + 1);
                check("done_latency", cyc, exp_done);
                fin   = 1;
                start = 1'b0;
            end else begin
                // Starts while busy must be ignored.
                start = ($urandom_range(0, 3) == 0);
            end
            prev_valid = term_valid;
            @(negedge clk);
        end
        if (!fin) check("run_timeout", 32'd0, 32'd1);
        start = 1'b0;
        check("done_one_cycle", {31'd0, done},       32'd0);
        check("idle_busy",      {31'd0, busy},       32'd0);
        check("idle_valid",     {31'd0, term_valid}, 32'd0);
        check("ovf_sticky",     {31'd0, overflow},   {31'd0, exp_ovf});
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; start = 1'b0; n_terms = 8'd0; term_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_seq(5, 100, -1);
        run_seq(20, 100, -1);
        run_seq(0, 100, -1);
        run_seq(4, 100, 2);
        run_seq(6, 100, -1);
        repeat (6) run_seq($urandom_range(1, 25), $urandom_range(30, 100), -1);
        run_seq(255, 60, -1);
        run_seq(20, 100, -1);

        // Asynchronous reset while idx 3 is pending.
        start = 1'b1; n_terms = 8'd6; term_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (term_valid && term_index == 8'd3) begin
                found      = 1;
                term_ready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check("reach_idx3", {31'd0, found}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_seq(5, 100, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
